// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller.
//   - acc_state_t        : accelerator sequencer states (RUN / WAIT)
//   - ACC_TIMEOUT_DEF    : default accelerator completion timeout in cycles
//   - reg_hit()          : register match term used by the hazard detector;
//                          register x0 never matches
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } acc_state_t;

  localparam int ACC_TIMEOUT_DEF = 1024;

  // True when source register src is produced by a stage writing dst with
  // the given qualifying enable. x0 is hard-wired zero, so it never matches.
  function automatic logic reg_hit(input logic [4:0] src,
                                   input logic [4:0] dst,
                                   input logic       en);
    return en && (src == dst) && (src != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_accel_wait_fsm.sv
// Accelerator sequencer for a multi-cycle instruction held in EX.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   accel_req_ex  : EX holds an accelerator instruction (level)
//   accel_done    : accelerator completion pulse
//   accel_start   : one-cycle start pulse, issued when the request is first
//                   seen in RUN
//   acc_err       : sticky flag, set when the accelerator times out
//   acs           : accelerator stall request (combinational)
// Handshake: the request is a level held by EX; the sequence ends either on
// accel_done (stall released in that same cycle) or on the last timeout
// cycle (treated as done). accel_done seen in RUN is ignored.
module accel_wait_fsm
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int ACC_TIMEOUT = ACC_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic accel_req_ex,
  input  logic accel_done,
  output logic accel_start,
  output logic acc_err,
  output logic acs
);

  localparam int TW = (ACC_TIMEOUT > 2) ? $clog2(ACC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACC_TIMEOUT - 1);

  acc_state_t    state, state_n, st_eff;
  logic [TW-1:0] timer, timer_n;
  logic          timeout;
  logic          err_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      timer   <= '0;
      acc_err <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (err_set) acc_err <= 1'b1;
    end
  end

  always_comb begin
    // While reset is asserted the outputs already reflect the RUN state the
    // register will hold after the edge, even if it was mid-WAIT.
    st_eff      = rst ? ST_RUN : state;
    state_n     = st_eff;
    timer_n     = timer;
    err_set     = 1'b0;
    accel_start = 1'b0;
    acs         = 1'b0;
    timeout     = (st_eff == ST_WAIT) && !accel_done && (timer == TIMER_LAST);
    case (st_eff)
      ST_RUN: begin
        if (accel_req_ex) begin
          accel_start = !rst;
          acs         = 1'b1;
          state_n     = ST_WAIT;
          timer_n     = '0;
        end
      end
      ST_WAIT: begin
        timer_n = timer + TW'(1);
        if (accel_done) begin
          state_n = ST_RUN;
        end else if (timeout) begin
          // Timeout releases the stall exactly like a completion.
          err_set = 1'b1;
          state_n = ST_RUN;
        end else begin
          acs = 1'b1;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller. Sits beside the ID-stage MEM
// forwarding unit and stalls whenever forwarding cannot supply an operand.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   branch_id, jalr_id          : ID instruction compares operands in ID
//   rs1_used_id, rs2_used_id    : ID instruction reads rs1 / rs2
//   rs1_id, rs2_id              : ID source registers
//   reg_write_ex, mem_read_ex   : EX writes rd / is a load
//   rd_ex                       : EX destination
//   mem_read_mem, rd_mem        : MEM is a load / MEM destination
//   redirect_id                 : branch taken / jump resolved in ID
//   accel_req_ex, accel_done    : accelerator request level / done pulse
//   accel_start                 : accelerator start pulse
//   stall_pc, stall_ifid        : hold PC / IF/ID
//   stall_idex                  : hold ID/EX
//   bubble_ex, bubble_mem       : NOP into ID/EX / EX/MEM
//   flush_ifid                  : kill IF/ID
//   acc_err                     : sticky accelerator timeout flag
//   stall_cnt                   : saturating count of stalled cycles
// Priority: accelerator stall > data hazard > redirect. A redirect that
// coincides with a stall is dropped; the ID instruction re-resolves later.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int ACC_TIMEOUT = ACC_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_id,
  input  logic             jalr_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             reg_write_ex,
  input  logic             mem_read_ex,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_mem,
  input  logic [4:0]       rd_mem,
  input  logic             redirect_id,
  input  logic             accel_req_ex,
  input  logic             accel_done,
  output logic             accel_start,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             flush_ifid,
  output logic             acc_err,
  output logic [CNT_W-1:0] stall_cnt
);

  logic is_br;
  logic hit_ex, hit_mem;
  logic brh, luh, dh, acs;

  accel_wait_fsm #(.ACC_TIMEOUT(ACC_TIMEOUT)) u_accel (
    .clk          (clk),
    .rst          (rst),
    .accel_req_ex (accel_req_ex),
    .accel_done   (accel_done),
    .accel_start  (accel_start),
    .acc_err      (acc_err),
    .acs          (acs)
  );

  // EX match qualifies on any register write; MEM match only on loads,
  // because ALU results in MEM are forwarded into ID for branch compares.
  always_comb begin
    is_br   = branch_id | jalr_id;
    hit_ex  = (rs1_used_id && reg_hit(rs1_id, rd_ex, reg_write_ex)) ||
              (rs2_used_id && reg_hit(rs2_id, rd_ex, reg_write_ex));
    hit_mem = (rs1_used_id && reg_hit(rs1_id, rd_mem, mem_read_mem)) ||
              (rs2_used_id && reg_hit(rs2_id, rd_mem, mem_read_mem));
    brh     = is_br & (hit_ex | hit_mem);
    luh     = ~is_br & mem_read_ex & hit_ex;
    dh      = brh | luh;

    stall_pc   = acs | dh;
    stall_ifid = acs | dh;
    stall_idex = acs;
    bubble_mem = acs;
    // During an accelerator stall ID/EX is held, so no bubble is inserted.
    bubble_ex  = dh & ~acs;
    flush_ifid = redirect_id & ~acs & ~dh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_ifid && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int ACC_TIMEOUT = 8;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             branch_id, jalr_id, rs1_used_id, rs2_used_id;
  logic [4:0]       rs1_id, rs2_id, rd_ex, rd_mem;
  logic             reg_write_ex, mem_read_ex, mem_read_mem;
  logic             redirect_id, accel_req_ex, accel_done;
  logic             accel_start, stall_pc, stall_ifid, stall_idex;
  logic             bubble_ex, bubble_mem, flush_ifid, acc_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic exp_q[$];

  hazard_stall_ctrl #(.ACC_TIMEOUT(ACC_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .branch_id(branch_id), .jalr_id(jalr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
    .mem_read_mem(mem_read_mem), .rd_mem(rd_mem),
    .redirect_id(redirect_id), .accel_req_ex(accel_req_ex), .accel_done(accel_done),
    .accel_start(accel_start), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_idex(stall_idex), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
    .flush_ifid(flush_ifid), .acc_err(acc_err), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled around the falling edge.
  task automatic clear_inputs();
    branch_id = 0; jalr_id = 0; rs1_used_id = 0; rs2_used_id = 0;
    rs1_id = 0; rs2_id = 0; reg_write_ex = 0; mem_read_ex = 0; rd_ex = 0;
    mem_read_mem = 0; rd_mem = 0; redirect_id = 0; accel_req_ex = 0; accel_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive_id(input logic br, input logic u1, input logic [4:0] r1,
                          input logic u2, input logic [4:0] r2);
    branch_id = br; rs1_used_id = u1; rs1_id = r1; rs2_used_id = u2; rs2_id = r2;
  endtask

  task automatic drive_ex(input logic wr, input logic ld, input logic [4:0] rd);
    reg_write_ex = wr; mem_read_ex = ld; rd_ex = rd;
  endtask

  task automatic drive_mem(input logic ld, input logic [4:0] rd);
    mem_read_mem = ld; rd_mem = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", stall_cnt); end
    n_chk++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", acc_err); end
    n_chk++; if (accel_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b expected 0", accel_start); end
    n_chk++; if ({stall_pc, stall_ifid, stall_idex, bubble_ex, bubble_mem, flush_ifid} !== 6'b0) begin
      n_fail++; $display("FAIL rst_ctrl: got %b expected 000000",
        {stall_pc, stall_ifid, stall_idex, bubble_ex, bubble_mem, flush_ifid}); end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw x5 in EX, add x?,x5 in ID
    drive_ex(1, 1, 5); drive_id(0, 1, 5, 1, 7);
    #1;
    n_chk++; if ({stall_pc, stall_ifid, bubble_ex, stall_idex} !== 4'b1110) begin
      n_fail++; $display("FAIL lu_stall: got %b expected 1110", {stall_pc, stall_ifid, bubble_ex, stall_idex}); end
    next_cycle();
    drive_ex(0, 0, 0); drive_mem(1, 5);
    #1;
    n_chk++; if ({stall_pc, stall_ifid, bubble_ex} !== 3'b000) begin
      n_fail++; $display("FAIL lu_release: got %b expected 000", {stall_pc, stall_ifid, bubble_ex}); end
    n_chk++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
    // rs2 hit but rs2 not used: no hazard
    next_cycle();
    drive_mem(0, 0); drive_ex(1, 1, 9); drive_id(0, 1, 3, 0, 9);
    #1;
    n_chk++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL lu_unused_rs2: got %b expected 0", stall_pc); end
    // rs2 used: hazard via rs2
    drive_id(0, 1, 3, 1, 9);
    #1;
    n_chk++; if (bubble_ex !== 1'b1) begin n_fail++; $display("FAIL lu_rs2: got %b expected 1", bubble_ex); end
    // x0 destination never matches
    drive_ex(1, 1, 0); drive_id(0, 1, 0, 1, 0);
    #1;
    n_chk++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL lu_x0: got %b expected 0", stall_pc); end
  endtask

  task automatic test_branch_after_load();
    do_reset();
    drive_ex(1, 1, 5); drive_id(1, 1, 5, 1, 0);   // beq x5,x0 after lw x5
    #1;
    n_chk++; if ({stall_pc, stall_ifid, bubble_ex} !== 3'b111) begin
      n_fail++; $display("FAIL bl_c1: got %b expected 111", {stall_pc, stall_ifid, bubble_ex}); end
    next_cycle();
    drive_ex(0, 0, 0); drive_mem(1, 5);
    #1;
    n_chk++; if ({stall_pc, stall_ifid, bubble_ex} !== 3'b111) begin
      n_fail++; $display("FAIL bl_c2: got %b expected 111", {stall_pc, stall_ifid, bubble_ex}); end
    next_cycle();
    drive_mem(0, 0);
    #1;
    n_chk++; if ({stall_pc, stall_ifid, bubble_ex} !== 3'b000) begin
      n_fail++; $display("FAIL bl_c3: got %b expected 000", {stall_pc, stall_ifid, bubble_ex}); end
    n_chk++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL bl_cnt: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_branch_after_alu();
    do_reset();
    drive_ex(1, 0, 5); jalr_id = 1; drive_id(0, 1, 5, 0, 0);   // jalr x5 after add x5
    #1;
    n_chk++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL ba_c1: got %b expected 1", stall_pc); end
    next_cycle();
    drive_ex(0, 0, 0); drive_mem(0, 5);   // ALU result in MEM is forwarded
    #1;
    n_chk++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL ba_c2: got %b expected 0", stall_pc); end
    n_chk++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL ba_cnt: got %0d expected 1", stall_cnt); end
    jalr_id = 0; drive_ex(1, 0, 0); drive_id(1, 1, 0, 1, 0);   // rd=0, rs=0
    #1;
    n_chk++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL ba_x0: got %b expected 0", stall_pc); end
  endtask

  task automatic test_accel();
    int starts;
    do_reset();
    starts = 0;
    // Stall pattern: 5 stalled cycles, then the done cycle, then idle.
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    accel_req_ex = 1;
    for (int c = 0; c < 7; c++) begin
      logic e;
      accel_done = (c == 5);
      if (c == 6) accel_req_ex = 0;
      if (c == 1) begin drive_ex(1, 1, 5); drive_id(0, 1, 5, 0, 0); end  // hidden load-use
      if (c == 2) begin drive_ex(0, 0, 0); drive_id(0, 0, 0, 0, 0); end
      #1;
      e = exp_q.pop_front();
      if (accel_start === 1'b1) starts++;
      n_chk++; if ({stall_idex, bubble_mem, stall_pc} !== {e, e, e}) begin
        n_fail++; $display("FAIL acc_c%0d: got %b expected %b", c, {stall_idex, bubble_mem, stall_pc}, {e, e, e}); end
      if (c == 1) begin
        n_chk++; if (bubble_ex !== 1'b0) begin n_fail++; $display("FAIL acc_prio_bubble_ex: got %b expected 0", bubble_ex); end
      end
      next_cycle();
    end
    n_chk++; if (starts != 1) begin n_fail++; $display("FAIL acc_starts: got %0d expected 1", starts); end
    n_chk++; if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL acc_cnt: got %0d expected 5", stall_cnt); end
    // accel_done in RUN is ignored
    accel_done = 1;
    #1;
    n_chk++; if ({stall_idex, accel_start, acc_err} !== 3'b000) begin
      n_fail++; $display("FAIL acc_done_run: got %b expected 000", {stall_idex, accel_start, acc_err}); end
    next_cycle();
    accel_done = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    accel_req_ex = 1;
    #1;
    n_chk++; if (accel_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start1: got %b expected 1", accel_start); end
    next_cycle();
    accel_done = 1;
    #1;
    n_chk++; if ({stall_idex, accel_start} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_rel1: got %b expected 00", {stall_idex, accel_start}); end
    next_cycle();
    accel_done = 0;   // second accelerator instruction now in EX
    #1;
    n_chk++; if ({accel_start, stall_idex} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_start2: got %b expected 11", {accel_start, stall_idex}); end
    next_cycle();
    accel_done = 1;
    #1;
    n_chk++; if (stall_idex !== 1'b0) begin n_fail++; $display("FAIL b2b_rel2: got %b expected 0", stall_idex); end
    next_cycle();
    accel_req_ex = 0; accel_done = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    accel_req_ex = 1;
    next_cycle();
    for (int w = 1; w <= 8; w++) begin
      logic e;
      e = (w < 8);
      #1;
      n_chk++; if ({stall_idex, stall_pc} !== {e, e}) begin
        n_fail++; $display("FAIL to_w%0d: got %b expected %b", w, {stall_idex, stall_pc}, {e, e}); end
      if (w == 7) begin
        n_chk++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b expected 0", acc_err); end
      end
      next_cycle();
    end
    accel_req_ex = 0;
    #1;
    n_chk++; if (acc_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", acc_err); end
    n_chk++; if (stall_cnt !== 4'd8) begin n_fail++; $display("FAIL to_cnt: got %0d expected 8", stall_cnt); end
    next_cycle();
    // Start another sequence, reset it mid-WAIT
    accel_req_ex = 1;
    #1;
    n_chk++; if ({accel_start, acc_err} !== 2'b11) begin
      n_fail++; $display("FAIL to_restart_sticky: got %b expected 11", {accel_start, acc_err}); end
    next_cycle();
    next_cycle();
    rst = 1;
    next_cycle();
    #1;
    n_chk++; if ({acc_err, accel_start} !== 2'b00) begin
      n_fail++; $display("FAIL to_rst_flags: got %b expected 00", {acc_err, accel_start}); end
    n_chk++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL to_rst_cnt: got %0d expected 0", stall_cnt); end
    next_cycle();
    rst = 0; accel_req_ex = 0;
    #1;
    n_chk++; if (stall_idex !== 1'b0) begin n_fail++; $display("FAIL to_post_rst: got %b expected 0", stall_idex); end
  endtask

  task automatic test_redirect();
    do_reset();
    redirect_id = 1;
    #1;
    n_chk++; if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL rd_plain: got %b expected 1", flush_ifid); end
    drive_ex(1, 1, 5); drive_id(0, 1, 5, 0, 0);
    #1;
    n_chk++; if ({flush_ifid, stall_pc} !== 2'b01) begin
      n_fail++; $display("FAIL rd_lu: got %b expected 01", {flush_ifid, stall_pc}); end
    next_cycle();
    drive_ex(0, 0, 0); drive_mem(1, 5);
    #1;
    n_chk++; if ({flush_ifid, stall_pc} !== 2'b10) begin
      n_fail++; $display("FAIL rd_next: got %b expected 10", {flush_ifid, stall_pc}); end
    drive_mem(0, 0); drive_id(0, 0, 0, 0, 0); accel_req_ex = 1;
    #1;
    n_chk++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL rd_acs: got %b expected 0", flush_ifid); end
    next_cycle();
    accel_done = 1;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    drive_ex(1, 1, 12); drive_id(0, 1, 12, 0, 0);
    for (int i = 0; i < 15; i++) next_cycle();
    #1;
    n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_15: got %0d expected 15", stall_cnt); end
    for (int i = 0; i < 5; i++) next_cycle();
    #1;
    n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt); end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_branch_after_alu();
    test_accel();
    test_back_to_back();
    test_timeout();
    test_redirect();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
